// File: rtl/risc16_pkg.sv
// Shared RiSC-16 datapath types and sizing constants.
package risc16_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned NUM_REGS  = 8;
   localparam int unsigned REG_IDX_W = 3;

   typedef logic [DATA_W-1:0]    word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : risc16_pkg

// File: rtl/registers.sv
// RiSC-16 register file: r0 reads as zero, one synchronous write port, two combinational read ports.
module registers
   import risc16_pkg::*;
#(
   parameter int unsigned DATA_W   = risc16_pkg::DATA_W,
   parameter int unsigned NUM_REGS = risc16_pkg::NUM_REGS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we_rf,
   input  logic [$clog2(NUM_REGS)-1:0] tgt,
   input  logic [DATA_W-1:0]           tgt_val,
   input  logic [$clog2(NUM_REGS)-1:0] src1,
   input  logic [$clog2(NUM_REGS)-1:0] src2,
   output logic [DATA_W-1:0]           src1_val,
   output logic [DATA_W-1:0]           src2_val
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   // Entry 0 is never written and never read, so it reduces to a constant.
   logic [DATA_W-1:0] regs [NUM_REGS];

   // Register array: asynchronous clear, write on rising edge, writes to r0 discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we_rf && (tgt != IDX_W'(0))) begin
         regs[tgt] <= tgt_val;
      end
   end

   // Read muxes with r0 forced to zero; no bypass from the pending write.
   assign src1_val = (src1 == IDX_W'(0)) ? DATA_W'(0) : regs[src1];
   assign src2_val = (src2 == IDX_W'(0)) ? DATA_W'(0) : regs[src2];

endmodule : registers

// File: tb/tb_registers.sv
// Directed self-checking bench for the RiSC-16 register file.
module tb_registers;
   import risc16_pkg::*;

   logic     clk;
   logic     rst;
   logic     we_rf;
   reg_idx_t tgt;
   word_t    tgt_val;
   reg_idx_t src1;
   reg_idx_t src2;
   word_t    src1_val;
   word_t    src2_val;

   int unsigned n_tests;
   int unsigned n_fail;

   // Hand-maintained expected register contents (index 0 always zero).
   word_t exp_reg [8];

   registers dut (
      .clk      (clk),
      .rst      (rst),
      .we_rf    (we_rf),
      .tgt      (tgt),
      .tgt_val  (tgt_val),
      .src1     (src1),
      .src2     (src2),
      .src1_val (src1_val),
      .src2_val (src2_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 8; i++) exp_reg[i] = 16'h0000;

      rst = 1'b1; we_rf = 1'b0; tgt = 3'd0; tgt_val = 16'h0000;
      src1 = 3'd0; src2 = 3'd0;
      tick();
      tick();

      // Reads during reset are zero for every index.
      for (int i = 0; i < 8; i++) begin
         src1 = reg_idx_t'(i); src2 = reg_idx_t'(7 - i); #1;
         check($sformatf("rst_hold_s1_%0d", i), src1_val, 16'h0000);
         check($sformatf("rst_hold_s2_%0d", 7 - i), src2_val, 16'h0000);
      end
      rst = 1'b0;
      tick();

      // Idle after reset: everything reads zero.
      for (int i = 0; i < 8; i++) begin
         src1 = reg_idx_t'(i); src2 = reg_idx_t'(i); #1;
         check($sformatf("idle_s1_%0d", i), src1_val, 16'h0000);
         check($sformatf("idle_s2_%0d", i), src2_val, 16'h0000);
      end

      // Basic write/read of r3.
      tgt = 3'd3; tgt_val = 16'd5; src1 = 3'd3; we_rf = 1'b0;
      tick();
      check("r3_no_we", src1_val, 16'h0000);
      we_rf = 1'b1;
      tick();
      we_rf = 1'b0;
      check("r3_written", src1_val, 16'd5);
      tick();
      check("r3_held", src1_val, 16'd5);
      exp_reg[3] = 16'd5;

      // Second register r4, then both ports at once.
      tgt = 3'd4; tgt_val = 16'd53; we_rf = 1'b1;
      tick();
      we_rf = 1'b0;
      src1 = 3'd4; #1;
      check("r4_read", src1_val, 16'd53);
      src1 = 3'd3; #1;
      check("r3_unaffected", src1_val, 16'd5);
      src2 = 3'd4; #1;
      check("dual_s1_r3", src1_val, 16'd5);
      check("dual_s2_r4", src2_val, 16'd53);
      exp_reg[4] = 16'd53;

      // Writes to r0 are discarded and disturb nothing.
      tgt = 3'd0; tgt_val = 16'hFFFF; we_rf = 1'b1;
      tick();
      we_rf = 1'b0;
      src1 = 3'd0; src2 = 3'd0; #1;
      check("r0_s1", src1_val, 16'h0000);
      check("r0_s2", src2_val, 16'h0000);
      for (int i = 1; i < 8; i++) begin
         src1 = reg_idx_t'(i); #1;
         check($sformatf("r0wr_keep_r%0d", i), src1_val, exp_reg[i]);
      end

      // No bypass: old value until the edge, new value after it.
      tgt = 3'd5; tgt_val = 16'h1234; src1 = 3'd5; we_rf = 1'b1; #1;
      check("nobyp_before", src1_val, 16'h0000);
      tick();
      check("nobyp_after", src1_val, 16'h1234);
      tgt_val = 16'h5678; #1;
      check("nobyp_hold_old", src1_val, 16'h1234);
      tick();
      check("nobyp_second", src1_val, 16'h5678);
      we_rf = 1'b0;
      exp_reg[5] = 16'h5678;
      src2 = 3'd5; #1;
      check("same_idx_s1", src1_val, 16'h5678);
      check("same_idx_s2", src2_val, 16'h5678);

      // Fill r1..r7 with 0x1111..0x7777.
      we_rf = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tgt = reg_idx_t'(i); tgt_val = 16'(16'h1111 * i);
         tick();
         exp_reg[i] = 16'(16'h1111 * i);
      end
      we_rf = 1'b0;
      for (int i = 1; i < 8; i++) begin
         src1 = reg_idx_t'(i); src2 = reg_idx_t'(8 - i); #1;
         check($sformatf("fill_s1_r%0d", i), src1_val, exp_reg[i]);
         check($sformatf("fill_s2_r%0d", 8 - i), src2_val, exp_reg[8 - i]);
      end

      // Asynchronous reset between edges clears reads before the next edge.
      @(posedge clk); #2;
      rst = 1'b1; #1;
      for (int i = 0; i < 8; i++) begin
         src1 = reg_idx_t'(i); src2 = reg_idx_t'(i); #0.1;
         check($sformatf("async_rst_s1_%0d", i), src1_val, 16'h0000);
         check($sformatf("async_rst_s2_%0d", i), src2_val, 16'h0000);
      end
      for (int i = 0; i < 8; i++) exp_reg[i] = 16'h0000;

      // Write attempted while reset is held is blocked.
      tgt = 3'd6; tgt_val = 16'hBEEF; we_rf = 1'b1;
      tick();
      src1 = 3'd6; #1;
      check("rst_blocks_write", src1_val, 16'h0000);

      // Release reset and write r2 at the following edge.
      rst = 1'b0; tgt = 3'd2; tgt_val = 16'hABCD;
      tick();
      we_rf = 1'b0;
      exp_reg[2] = 16'hABCD;
      for (int i = 0; i < 8; i++) begin
         src1 = reg_idx_t'(i); src2 = reg_idx_t'(i); #1;
         check($sformatf("post_rst_s1_r%0d", i), src1_val, exp_reg[i]);
         check($sformatf("post_rst_s2_r%0d", i), src2_val, exp_reg[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_registers
